// File: rtl/pcie_dll_acknak_sched_pkg.sv
// Shared types and constants for the DLL Ack/Nak scheduler.
package PCIe_PKG;
  localparam int PCIe_SEQ_W = 12;
  localparam logic [7:0] DLLP_ACK = 8'h00;
  localparam logic [7:0] DLLP_NAK = 8'h10;

  typedef struct packed {
    logic [7:0]            ack_or_nak;
    logic [PCIe_SEQ_W-1:0] seq_num;
  } dllp_packet;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    HOLD = 2'b10
  } acknak_state_e;
endpackage

// File: rtl/pcie_dll_acknak_sched_timer.sv
// Saturating pending-Ack timer; expired reflects the value it would hold after this edge.
module pcie_acknak_timer #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expired
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT);

  logic [TW-1:0] cnt, cnt_inc;

  always_comb cnt_inc = (run && cnt != TMAX) ? cnt + TW'(1) : cnt;
  assign expired = (cnt_inc == TMAX);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else        cnt <= clear ? '0 : cnt_inc;
endmodule

// File: rtl/pcie_dll_acknak_sched.sv
// Ack/Nak DLLP scheduler: coalesces Acks, times them out, collapses Nak episodes.
// Optional PCIE_ACKNAK_STATS_EN builds saturating Ack/Nak handshake counters.
module pcie_dll_acknak_sched
  import PCIe_PKG::*;
#(
  parameter int ACK_COALESCE = 4,
  parameter int ACK_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dllp_valid_i,
  input  dllp_packet  dllp_i,
  output logic        dllp_valid_o,
  output dllp_packet  dllp_o,
  input  logic        dllp_ready_i,
  output logic [15:0] ack_cnt_o,
  output logic [15:0] nak_cnt_o
);
  localparam int GW = $clog2(ACK_COALESCE + 1);
  localparam logic [GW-1:0] GMAX = GW'(ACK_COALESCE);

  acknak_state_e         state;
  logic [PCIe_SEQ_W-1:0] last_good_seq, seq_n;
  logic [GW-1:0]         good_cnt, good_cnt_n;
  logic ack_pend, nak_pend, nak_sched;
  logic ack_pend_n, nak_pend_n, nak_sched_n;
  logic good, bad, slot_free, nak_load, ack_load, any_load, expired;

  // Next-state values fold in this edge's verdict so a trigger loads immediately.
  always_comb begin
    good        = dllp_valid_i && (dllp_i.ack_or_nak == DLLP_ACK);
    bad         = dllp_valid_i && (dllp_i.ack_or_nak == DLLP_NAK);
    seq_n       = good ? dllp_i.seq_num : last_good_seq;
    ack_pend_n  = ack_pend | good;
    good_cnt_n  = (good && good_cnt != GMAX) ? good_cnt + GW'(1) : good_cnt;
    nak_pend_n  = nak_pend | (bad & ~nak_sched);
    nak_sched_n = ~good & (nak_sched | bad);
    slot_free   = ~dllp_valid_o | dllp_ready_i;
    nak_load    = slot_free & nak_pend_n;
    ack_load    = slot_free & ~nak_pend_n & ack_pend_n & ((good_cnt_n == GMAX) | expired);
    any_load    = nak_load | ack_load;
  end

  pcie_acknak_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (ack_pend),
    .clear   (any_load),
    .expired (expired)
  );

  // HOLD is the only state with bit 1 set, so valid comes straight off a flop.
  assign dllp_valid_o = state[1];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      dllp_o        <= '0;
      last_good_seq <= '1;
      good_cnt      <= '0;
      ack_pend      <= 1'b0;
      nak_pend      <= 1'b0;
      nak_sched     <= 1'b0;
    end else begin
      last_good_seq <= seq_n;
      nak_sched     <= nak_sched_n;
      ack_pend      <= ack_pend_n & ~any_load;
      nak_pend      <= nak_pend_n & ~nak_load;
      good_cnt      <= any_load ? '0 : good_cnt_n;
      if (any_load) dllp_o <= '{ack_or_nak: nak_load ? DLLP_NAK : DLLP_ACK, seq_num: seq_n};
      if (any_load || (dllp_valid_o && !dllp_ready_i)) state <= HOLD;
      else if (ack_pend_n || nak_pend_n)               state <= PEND;
      else                                             state <= IDLE;
    end

`ifdef PCIE_ACKNAK_STATS_EN
  logic hs;
  assign hs = dllp_valid_o & dllp_ready_i;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ack_cnt_o <= '0;
      nak_cnt_o <= '0;
    end else if (hs) begin
      if (dllp_o.ack_or_nak == DLLP_ACK && ack_cnt_o != 16'hFFFF) ack_cnt_o <= ack_cnt_o + 16'd1;
      if (dllp_o.ack_or_nak == DLLP_NAK && nak_cnt_o != 16'hFFFF) nak_cnt_o <= nak_cnt_o + 16'd1;
    end
`else
  assign ack_cnt_o = '0;
  assign nak_cnt_o = '0;
`endif
endmodule
